// File: rtl/adder_seq_pkg.sv
// Shared types and defaults for the adder operand sequencer.
package adder_seq_pkg;
  localparam int DEFAULT_WIDTH  = 4;
  localparam int DEFAULT_SETTLE = 2;
  localparam int COUNT_W        = 8;
  localparam int SETTLE_W       = 4;

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} seq_state_t;
endpackage

// File: rtl/adder_operand_sequencer_settle_counter.sv
// Down counter measuring the adder settle window; zero flags window expiry.
module settle_counter
  import adder_seq_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [SETTLE_W-1:0] load_val,
  input  logic                dec,
  output logic                zero
);
  logic [SETTLE_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                     cnt_q <= '0;
    else if (load)                 cnt_q <= load_val;
    else if (dec && cnt_q != '0)   cnt_q <= cnt_q - 1'b1;
  end

  assign zero = (cnt_q == '0);
endmodule

// File: rtl/adder_operand_sequencer.sv
// Drives registered operands onto an external transport-delay adder, waits for
// it to settle, captures {co, sum} and hands it off on a valid/ready handshake.
module adder_operand_sequencer
  import adder_seq_pkg::*;
#(
  parameter int WIDTH         = DEFAULT_WIDTH,
  parameter int SETTLE_CYCLES = DEFAULT_SETTLE
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_ci,
  output logic [WIDTH-1:0]   add_a,
  output logic [WIDTH-1:0]   add_b,
  output logic               add_ci,
  input  logic [WIDTH-1:0]   add_sum,
  input  logic               add_co,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_sum,
  output logic               out_co,
  output logic [COUNT_W-1:0] carry_count
);
  // Counter holds remaining edges after the accept edge itself.
  localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES - 1);

  seq_state_t state_q, state_d;
  logic accept, capture, release_res, dec, zero;

  settle_counter u_settle (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .load_val (SETTLE_LOAD),
    .dec      (dec),
    .zero     (zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    capture     = 1'b0;
    release_res = 1'b0;
    dec         = 1'b0;
    case (state_q)
      IDLE: if (in_valid) begin
        accept  = 1'b1;
        state_d = SETTLE;
      end
      SETTLE: if (zero) begin
        capture = 1'b1;
        state_d = HOLD;
      end else begin
        dec = 1'b1;
      end
      HOLD: if (out_ready) begin
        release_res = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready = (state_q == IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      add_a  <= '0;
      add_b  <= '0;
      add_ci <= 1'b0;
    end else if (accept) begin
      add_a  <= in_a;
      add_b  <= in_b;
      add_ci <= in_ci;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid   <= 1'b0;
      out_sum     <= '0;
      out_co      <= 1'b0;
      carry_count <= '0;
    end else begin
      if (capture) begin
        out_valid <= 1'b1;
        out_sum   <= add_sum;
        out_co    <= add_co;
        if (add_co && carry_count != '1) carry_count <= carry_count + 1'b1;
      end else if (release_res) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_adder_operand_sequencer.sv
// Bench: two sequencer instances (default and SETTLE_CYCLES=1), each feeding a
// behavioural 12-unit transport-delay adder, checked against plain arithmetic.
module tb_adder_operand_sequencer;
  logic clk = 1'b0, clk2 = 1'b0, reset = 1'b1;
  always #5  clk  = ~clk;
  always #10 clk2 = ~clk2;

  // default instance
  logic in_valid = 0, in_ready, in_ci = 0, add_ci, add_co, out_valid, out_ready = 0, out_co;
  logic [3:0] in_a = 0, in_b = 0, add_a, add_b, add_sum, out_sum;
  logic [7:0] carry_count;
  logic [4:0] add_res = '0;

  // SETTLE_CYCLES=1 instance
  logic in_valid2 = 0, in_ready2, in_ci2 = 0, add_ci2, add_co2, out_valid2, out_ready2 = 0, out_co2;
  logic [3:0] in_a2 = 0, in_b2 = 0, add_a2, add_b2, add_sum2, out_sum2;
  logic [7:0] carry_count2;
  logic [4:0] add_res2 = '0;

  adder_operand_sequencer #(.WIDTH(4), .SETTLE_CYCLES(2)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_ci(in_ci), .add_a(add_a), .add_b(add_b),
    .add_ci(add_ci), .add_sum(add_sum), .add_co(add_co), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum), .out_co(out_co), .carry_count(carry_count));

  adder_operand_sequencer #(.WIDTH(4), .SETTLE_CYCLES(1)) u_dut1 (
    .clk(clk2), .reset(reset), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_a(in_a2), .in_b(in_b2), .in_ci(in_ci2), .add_a(add_a2), .add_b(add_b2),
    .add_ci(add_ci2), .add_sum(add_sum2), .add_co(add_co2), .out_valid(out_valid2),
    .out_ready(out_ready2), .out_sum(out_sum2), .out_co(out_co2), .carry_count(carry_count2));

  // transport-delay adders: every operand change schedules its own result
  always @(add_a or add_b or add_ci)
    add_res <= #12 ({1'b0, add_a} + {1'b0, add_b} + {4'b0, add_ci});
  always @(add_a2 or add_b2 or add_ci2)
    add_res2 <= #12 ({1'b0, add_a2} + {1'b0, add_b2} + {4'b0, add_ci2});
  assign {add_co, add_sum}   = add_res;
  assign {add_co2, add_sum2} = add_res2;

  int checks = 0, errors = 0;
  int cc_model = 0;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       ci;
    logic [4:0] exp;
  } vec_t;
  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_capture(input logic [4:0] r);
    if (r[4] && cc_model < 255) cc_model++;
  endtask

  task automatic do_op(input logic [3:0] a, input logic [3:0] b, input logic ci,
                       output int lat, output logic [4:0] res);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    check("accept_wait", in_ready, 1);
    in_a = a; in_b = b; in_ci = ci; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    check("add_a", add_a, a);
    check("add_b", add_b, b);
    check("add_ci", add_ci, ci);
    lat = 0;
    while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    res = {out_co, out_sum};
    @(negedge clk); out_ready = 1;
    @(posedge clk); #1; out_ready = 0;
    check("release_valid", out_valid, 0);
  endtask

  initial begin
    int lat, n, cyc, last_acc, n_acc;
    logic [4:0] res, exp;
    logic [3:0] ra, rb, la, lb;
    logic rci, lci, have_acc;
    logic [4:0] q[$];

    vecs[0] = '{4'h9, 4'h8, 1'b1, 5'h12};
    vecs[1] = '{4'h3, 4'h4, 1'b0, 5'h07};
    vecs[2] = '{4'hF, 4'hF, 1'b1, 5'h1F};
    vecs[3] = '{4'h0, 4'h0, 1'b0, 5'h00};
    vecs[4] = '{4'hF, 4'h1, 1'b0, 5'h10};
    vecs[5] = '{4'hA, 4'h5, 1'b0, 5'h0F};
    vecs[6] = '{4'h7, 4'h8, 1'b1, 5'h10};
    vecs[7] = '{4'h8, 4'h8, 1'b0, 5'h10};

    // reset state
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_add", {add_a, add_b, add_ci}, 0);
    check("rst_out", {out_co, out_sum}, 0);
    check("rst_cc", carry_count, 0);
    @(negedge clk); reset = 0;

    // table vectors
    foreach (vecs[i]) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].ci, lat, res);
      model_capture(vecs[i].exp);
      check("vec_latency", lat, 2);
      check("vec_result", res, vecs[i].exp);
      check("vec_cc", carry_count, cc_model);
    end

    // hold with out_ready low; a second offer must not be latched
    @(negedge clk);
    in_a = 4'h3; in_b = 4'h4; in_ci = 0; in_valid = 1;
    @(posedge clk); #1; in_valid = 0;
    n = 0;
    while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
    check("hold_latency", n, 2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_valid", out_valid, 1);
      check("hold_result", {out_co, out_sum}, 5'h07);
      check("hold_in_ready", in_ready, 0);
      if (i == 1) begin in_a = 4'h1; in_b = 4'h1; in_ci = 1; in_valid = 1; end
    end
    in_valid = 0;
    check("hold_no_latch", {add_a, add_b, add_ci}, {4'h3, 4'h4, 1'b0});
    out_ready = 1;
    @(posedge clk); #1; out_ready = 0;
    check("hold_released", {out_valid, in_ready}, 2'b01);
    check("hold_result_kept", {out_co, out_sum}, 5'h07);

    // back-to-back with in_valid and out_ready held high
    have_acc = 0; last_acc = 0; n_acc = 0; la = 0; lb = 0; lci = 0;
    out_ready = 1;
    for (cyc = 0; cyc < 48; cyc++) begin
      @(negedge clk);
      if (have_acc) check("b2b_add_stable", {add_a, add_b, add_ci}, {la, lb, lci});
      if (out_valid) begin
        if (q.size() == 0) check("b2b_spurious", out_valid, 0);
        else begin
          exp = q.pop_front();
          model_capture(exp);
          check("b2b_result", {out_co, out_sum}, exp);
          check("b2b_cc", carry_count, cc_model);
        end
      end
      ra = 4'($urandom); rb = 4'($urandom); rci = 1'($urandom);
      in_a = ra; in_b = rb; in_ci = rci;
      in_valid = (cyc < 40);
      if (in_ready && in_valid) begin
        if (have_acc) check("b2b_interval", cyc - last_acc, 4);
        q.push_back({1'b0, ra} + {1'b0, rb} + {4'b0, rci});
        la = ra; lb = rb; lci = rci; last_acc = cyc; have_acc = 1; n_acc++;
      end
    end
    in_valid = 0; out_ready = 0;
    check("b2b_drained", q.size(), 0);
    check("b2b_accepts", n_acc >= 9, 1);

    // reset midway through SETTLE
    @(negedge clk);
    in_a = 4'hF; in_b = 4'hF; in_ci = 1; in_valid = 1;
    @(posedge clk); #3; in_valid = 0; reset = 1;
    #1;
    check("mid_rst_add", {add_a, add_b, add_ci}, 0);
    check("mid_rst_out", {out_valid, out_co, out_sum}, 0);
    check("mid_rst_cc", carry_count, 0);
    check("mid_rst_in_ready", in_ready, 1);
    cc_model = 0;
    @(posedge clk); @(negedge clk); reset = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("mid_rst_no_valid", {out_valid, in_ready}, 2'b01);
    end

    // carry_count saturation
    for (int i = 0; i < 256; i++) begin
      do_op(4'hF, 4'h1, 1'b0, lat, res);
      model_capture(5'h10);
      check("sat_result", res, 5'h10);
      if (i >= 253) check("sat_cc", carry_count, cc_model);
    end
    check("sat_final", carry_count, 8'd255);

    // random operations
    for (int i = 0; i < 30; i++) begin
      ra = 4'($urandom); rb = 4'($urandom); rci = 1'($urandom);
      exp = {1'b0, ra} + {1'b0, rb} + {4'b0, rci};
      do_op(ra, rb, rci, lat, res);
      model_capture(exp);
      check("rnd_latency", lat, 2);
      check("rnd_result", res, exp);
      check("rnd_cc", carry_count, cc_model);
    end

    // SETTLE_CYCLES=1 at a 20-unit period
    @(negedge clk2);
    check("s1_in_ready", in_ready2, 1);
    in_a2 = 4'hF; in_b2 = 4'hF; in_ci2 = 1; in_valid2 = 1;
    @(posedge clk2); #1; in_valid2 = 0;
    n = 0;
    while (!out_valid2 && n < 20) begin @(posedge clk2); #1; n++; end
    check("s1_latency", n, 1);
    check("s1_result", {out_co2, out_sum2}, 5'h1F);
    check("s1_cc", carry_count2, 1);
    @(negedge clk2); out_ready2 = 1;
    @(posedge clk2); #1; out_ready2 = 0;
    check("s1_release", {out_valid2, in_ready2}, 2'b01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end
endmodule
